// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multi-cycle MIPS control path.
// Holds the supported opcodes, the FSM state encoding, and the select codes
// driven toward the datapath and the ALU control decoder.
package mips_pkg;

    localparam int ST_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    function automatic logic is_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mips_multicycle_control_fsm_if.sv
// mips_multicycle_control_fsm_if: bundle between the control FSM and the datapath.
// master: the control FSM (takes IR fields, ALU zero, memory ready; drives
//         memory handshake, mux selects, write strobes, ALU op, status).
// slave:  the datapath / memory side, the mirror image.
interface mips_multicycle_control_fsm_if;

    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_mem_req;
    logic       o_mem_write;
    logic       o_i_or_d;
    logic       o_ir_write;
    logic       o_pc_en;
    logic [1:0] o_pc_src;
    logic       o_reg_write;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op_code;
    logic       o_alu_is_signed;
    logic       o_illegal_op;
    logic       o_retire;
    logic [3:0] o_state;

    modport master (
        input  i_opcode, i_funct, i_zero, i_mem_ready,
        output o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_en, o_pc_src,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
               o_alu_op_code, o_alu_is_signed, o_illegal_op, o_retire, o_state
    );

    modport slave (
        output i_opcode, i_funct, i_zero, i_mem_ready,
        input  o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_en, o_pc_src,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
               o_alu_op_code, o_alu_is_signed, o_illegal_op, o_retire, o_state
    );

endinterface

// File: rtl/mips_multicycle_control_fsm.sv
// mips_multicycle_control_fsm: main control FSM of the multi-cycle MIPS datapath.
// Ports: i_clk (rising edge), i_rst_n (async, active-low),
//        bus (master modport): IR opcode/funct, ALU zero, memory ready in;
//        memory handshake, datapath selects, write strobes, ALU op/signedness,
//        sticky illegal-opcode flag, retire pulse and debug state out.
module mips_multicycle_control_fsm
    import mips_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    mips_multicycle_control_fsm_if.master bus
);

    state_t     state;
    state_t     next;
    logic       illegal;
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_signed;
    logic       retire;
    logic       unused_funct;

    // Only funct[0] matters here; the rest goes to the ALU control decoder.
    assign unused_funct = ^bus.i_funct[5:1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state   <= next;
            illegal <= illegal | (state == S_DECODE && !is_supported(bus.i_opcode));
        end
    end

    always_comb begin
        next       = S_FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        is_signed  = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.i_mem_ready;
                pc_write  = bus.i_mem_ready;
                next      = bus.i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut gets PC+4+(imm<<2) so a branch can use it next cycle.
                alu_src_b = SRCB_IMM_SH;
                is_signed = 1'b1;
                retire    = !is_supported(bus.i_opcode);
                case (bus.i_opcode)
                    OP_LW, OP_SW:      next = S_MEMADR;
                    OP_RTYPE:          next = S_EXEC;
                    OP_BEQ, OP_BNE:    next = S_BRANCH;
                    OP_ADDI, OP_ADDIU: next = S_ADDIEX;
                    OP_J:              next = S_JUMP;
                    default:           next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                is_signed = 1'b1;
                next      = (bus.i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                next    = bus.i_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = bus.i_mem_ready;
                next      = bus.i_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                // funct[0] set marks addu/subu.
                is_signed = ~bus.i_funct[0];
                next      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                is_signed = 1'b1;
                pc_src    = PC_ALUOUT;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                is_signed = ~bus.i_opcode[0];
                next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing fires while the FSM is held;
    // selects need no gating since reset parks the state in FETCH.
    // BEQ (opcode[0]=0) is taken on zero, BNE (opcode[0]=1) on nonzero.
    assign bus.o_mem_req       = i_rst_n & mem_req;
    assign bus.o_mem_write     = i_rst_n & mem_write;
    assign bus.o_ir_write      = i_rst_n & ir_write;
    assign bus.o_pc_en         = i_rst_n & (pc_write | (branch & (bus.i_zero ^ bus.i_opcode[0])));
    assign bus.o_reg_write     = i_rst_n & reg_write;
    assign bus.o_retire        = i_rst_n & retire;
    assign bus.o_i_or_d        = i_or_d;
    assign bus.o_pc_src        = pc_src;
    assign bus.o_reg_dst       = reg_dst;
    assign bus.o_mem_to_reg    = mem_to_reg;
    assign bus.o_alu_src_a     = alu_src_a;
    assign bus.o_alu_src_b     = alu_src_b;
    assign bus.o_alu_op_code   = alu_op;
    assign bus.o_alu_is_signed = is_signed;
    assign bus.o_illegal_op    = illegal;
    assign bus.o_state         = state;

endmodule

// File: tb/tb_mips_multicycle_control_fsm.sv
// tb_mips_multicycle_control_fsm: directed and randomized checks of the control FSM.
module tb_mips_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_control_fsm_if bus();

    mips_multicycle_control_fsm dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       is_signed;
        logic       illegal;
        logic       retire;
    } obs_t;

    // An instruction is the ordered list of states it walks through.
    typedef struct packed {
        logic [2:0]      len;
        logic [4:0][3:0] st;
    } route_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;
    logic ill_m = 1'b0;
    int   rst_cnt = 0;

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h23, 6'h2B};
    endfunction

    function automatic route_t route_of(input logic [5:0] op);
        route_t r;
        case (op)
            6'h23:        begin r.len = 3'd5; r.st = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}; end
            6'h2B:        begin r.len = 3'd4; r.st = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}; end
            6'h00:        begin r.len = 3'd4; r.st = {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}; end
            6'h08, 6'h09: begin r.len = 3'd4; r.st = {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}; end
            6'h04, 6'h05: begin r.len = 3'd3; r.st = {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}; end
            6'h02:        begin r.len = 3'd3; r.st = {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}; end
            default:      begin r.len = 3'd2; r.st = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}; end
        endcase
        return r;
    endfunction

    function automatic logic is_wait(input int ph);
        return ph inside {0, 3, 5};
    endfunction

    function automatic obs_t expect_now();
        route_t r = route_of(bus.i_opcode);
        int     ph = rst_n ? int'(r.st[k]) : 0;
        logic   rdy = bus.i_mem_ready;
        obs_t   e = '0;
        e.st = 4'(ph);
        case (ph)
            0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
            1:  begin e.alu_src_b = 2'b11; e.is_signed = 1; end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.is_signed = 1; end
            3:  begin e.mem_req = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_req = 1; e.mem_write = 1; e.i_or_d = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; e.is_signed = ~bus.i_funct[0]; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin
                e.alu_src_a = 1; e.alu_op = 2'b01; e.is_signed = 1; e.pc_src = 2'b01;
                e.pc_en = (bus.i_opcode == 6'h04) ? bus.i_zero : ~bus.i_zero;
            end
            9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.is_signed = (bus.i_opcode == 6'h08); end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pc_en = 1; end
            default: ;
        endcase
        e.retire = (k == int'(r.len) - 1) && (!is_wait(ph) || rdy);
        if (!rst_n) begin
            e.mem_req = 0; e.mem_write = 0; e.ir_write = 0;
            e.pc_en = 0; e.reg_write = 0; e.retire = 0;
        end
        e.illegal = rst_n & ill_m;
        return e;
    endfunction

    function automatic obs_t observe();
        return {bus.o_state, bus.o_mem_req, bus.o_mem_write, bus.o_i_or_d, bus.o_ir_write,
                bus.o_pc_en, bus.o_pc_src, bus.o_reg_write, bus.o_reg_dst, bus.o_mem_to_reg,
                bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op_code, bus.o_alu_is_signed,
                bus.o_illegal_op, bus.o_retire};
    endfunction

    // Every negedge: compare against the model, then advance the model with
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        obs_t   e;
        obs_t   g;
        route_t r;
        int     ph;
        e = expect_now();
        g = observe();
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL cycle_check t=%0t got=%h exp=%h", $time, g, e);
        end
        if (!rst_n) begin
            k = 0;
            ill_m = 1'b0;
        end else begin
            r = route_of(bus.i_opcode);
            ph = int'(r.st[k]);
            if (ph == 1 && !legal(bus.i_opcode)) ill_m = 1'b1;
            if (!is_wait(ph) || bus.i_mem_ready) k = (k == int'(r.len) - 1) ? 0 : k + 1;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic z);
        @(posedge clk);
        #1;
        bus.i_mem_ready = r;
        bus.i_zero = z;
        #3;
    endtask

    initial begin
        logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h23, 6'h2B};
        bus.i_opcode = 6'h00;
        bus.i_funct = 6'h20;
        bus.i_mem_ready = 1'b1;
        bus.i_zero = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4;
        chk("rst_strobes", int'({bus.o_mem_req, bus.o_mem_write, bus.o_ir_write,
                                 bus.o_pc_en, bus.o_reg_write, bus.o_retire}), 0);
        chk("rst_state", int'(bus.o_state), 0);
        chk("rst_srcb", int'(bus.o_alu_src_b), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        chk("fetch_ir_write", int'(bus.o_ir_write), 1);
        chk("fetch_pc_en", int'(bus.o_pc_en), 1);
        step(1, 0); chk("r_decode", int'(bus.o_state), 1);
        step(1, 0); chk("r_exec", int'(bus.o_state), 6);
        chk("r_alu_op", int'(bus.o_alu_op_code), 2);
        chk("add_signed", int'(bus.o_alu_is_signed), 1);
        step(1, 0); chk("r_aluwb", int'(bus.o_state), 7);
        chk("r_wb", int'({bus.o_reg_write, bus.o_reg_dst, bus.o_retire}), 7);
        step(1, 0); bus.i_funct = 6'h21;
        step(1, 0);
        step(1, 0); chk("addu_unsigned", int'(bus.o_alu_is_signed), 0);
        step(1, 0);
        step(1, 0); bus.i_opcode = 6'h23;
        step(1, 0);
        step(1, 0); chk("lw_memadr", int'(bus.o_state), 2);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 0);
            chk("lw_memrd_hold", int'({bus.o_state, bus.o_mem_req, bus.o_i_or_d}), (3 << 2) | 3);
        end
        step(1, 0); chk("lw_memwb", int'({bus.o_state, bus.o_mem_to_reg, bus.o_reg_write}), (4 << 2) | 3);
        step(1, 0); bus.i_opcode = 6'h04;
        step(1, 0);
        step(1, 1); chk("beq_taken", int'({bus.o_state, bus.o_pc_en, bus.o_pc_src}), (8 << 3) | 5);
        step(1, 0); bus.i_opcode = 6'h05;
        step(1, 0);
        step(1, 1); chk("bne_zero_not_taken", int'(bus.o_pc_en), 0);
        step(1, 0);
        step(1, 0);
        step(1, 0); chk("bne_taken", int'(bus.o_pc_en), 1);
        step(1, 0); bus.i_opcode = 6'h3F;
        step(1, 0); chk("ill_retire", int'({bus.o_state, bus.o_retire}), 3);
        step(1, 0); chk("ill_flag", int'({bus.o_state, bus.o_illegal_op}), 1);
        bus.i_opcode = 6'h08;
        step(1, 0);
        step(1, 0); chk("addi_exec", int'({bus.o_state, bus.o_alu_is_signed}), (9 << 1) | 1);
        step(1, 0); chk("addi_wb_sticky", int'({bus.o_reg_write, bus.o_illegal_op}), 3);
        step(1, 0); bus.i_opcode = 6'h2B;
        step(1, 0);
        step(1, 0);
        step(0, 0); chk("sw_memwr", int'({bus.o_state, bus.o_mem_write}), (5 << 1) | 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw_async_rst", int'({bus.o_state, bus.o_mem_write, bus.o_illegal_op}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        chk("post_rst_fetch", int'({bus.o_state, bus.o_mem_req, bus.o_illegal_op}), 2);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                rst_cnt = $urandom_range(1, 2);
            end
            bus.i_mem_ready = ($urandom_range(0, 3) != 0);
            bus.i_zero = 1'($urandom_range(0, 1));
            if (k == 0) begin
                bus.i_opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                bus.i_funct = ($urandom_range(0, 1) == 0) ? 6'(6'h20 + $urandom_range(0, 3)) : 6'($urandom);
            end
        end
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control_fsm.md
Name: mips_multicycle_control_fsm

Overview:
Main control unit of the multi-cycle MIPS datapath. Decodes the IR opcode and sequences each instruction through fetch/decode/execute/memory/writeback states. Drives datapath mux selects and write strobes, plus the 2-bit ALU op-code and signedness flag consumed directly by the ALU control decoder (control_unit_alu_mips). Stalls on a memory ready handshake.

Parameters:
ST_W, 4, state register width
OP_RTYPE, 6'h00; OP_J, 6'h02; OP_BEQ, 6'h04; OP_BNE, 6'h05; OP_ADDI, 6'h08; OP_ADDIU, 6'h09; OP_LW, 6'h23; OP_SW, 6'h2B, supported opcodes

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_opcode  in  6  IR[31:26], stable from DECODE onward
i_funct  in  6  IR[5:0]
i_zero  in  1  ALU zero flag
i_mem_ready  in  1  memory accepted/completed current access
o_mem_req  out  1  memory access request
o_mem_write  out  1  memory write strobe
o_i_or_d  out  1  address mux: 0=PC, 1=ALUOut
o_ir_write  out  1  IR load enable
o_pc_en  out  1  PC load enable (write or taken branch)
o_pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
o_reg_write  out  1  register file write enable
o_reg_dst  out  1  0=rt, 1=rd
o_mem_to_reg  out  1  0=ALUOut, 1=mem data
o_alu_src_a  out  1  0=PC, 1=rs
o_alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
o_alu_op_code  out  2  00=add, 01=sub, 10=by funct
o_alu_is_signed  out  1  signedness to ALU control
o_illegal_op  out  1  sticky: unsupported opcode decoded
o_retire  out  1  one-cycle pulse on final cycle of each instruction
o_state  out  4  current state, debug

Behaviour:
- Whole instruction is handled only by mips_multicycle_control_fsm; Moore outputs decoded from state, except o_pc_en and handshake-qualified strobes.
- Reset (i_rst_n low, async): state=FETCH; o_illegal_op=0. While i_rst_n low, all strobes (o_mem_req, o_mem_write, o_ir_write, o_pc_en, o_reg_write, o_retire) forced 0. Selects take FETCH values: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, is_signed=0, pc_src=00, reg_dst=0, mem_to_reg=0.
- Unlisted selects in any state = 0. Unlisted strobes in any state = 0.
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 -> FETCH next cycle, no strobes.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=i_mem_ready. Stay until i_mem_ready=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, is_signed=1 (branch target precompute). Next: LW/SW->MEMADR; RTYPE->EXEC; BEQ/BNE->BRANCH; ADDI/ADDIU->ADDIEX; J->JUMP. Other opcode: set o_illegal_op, pulse o_retire, ->FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, is_signed=1. LW->MEMRD, SW->MEMWR.
- MEMRD: mem_req=1, i_or_d=1; wait for i_mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; ->FETCH.
- MEMWR: mem_req=1, mem_write=1 (held while waiting), i_or_d=1; on i_mem_ready retire, ->FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, is_signed=~i_funct[0] (add/sub signed, addu/subu unsigned). ->ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; ->FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, is_signed=1, pc_src=01; o_pc_en=i_zero XOR i_opcode[0] (beq taken on zero, bne on nonzero); retire; ->FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, is_signed=~i_opcode[0]. ->ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; retire; ->FETCH.
- JUMP: pc_src=10, o_pc_en=1; retire; ->FETCH.
- o_pc_en = pc_write | (branch & taken). Cycle counts with zero wait: LW 5, SW 4, R/ADDI 4, BEQ/BNE/J 3.
- i_mem_ready ignored outside FETCH/MEMRD/MEMWR. o_illegal_op cleared only by reset.
- Reset mid-instruction: abort immediately, no partial strobes after release; restart at FETCH.

Decomposition:
- Package mips_pkg: opcode localparams, state encoding, alu_op codes (ADD=00, SUB=01, FUNCT=10), alu_src_b codes, pc_src codes; shared with control_unit_alu_mips bench.
- Single module; no sub-module required (next-state and output decode as two always blocks).

Test Plan:
- Reset held low with i_mem_ready=1 -> all strobes 0, o_state=0; release -> ir_write=1 and pc_en=1 in first FETCH cycle.
- R-type funct 6'h20, ready=1 -> states 0,1,6,7; in EXEC alu_op=10, is_signed=1; ALUWB reg_write=1, reg_dst=1, retire=1; funct 6'h21 -> is_signed=0.
- LW with i_mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles with mem_req=1, i_or_d=1; then MEMWB mem_to_reg=1, reg_write=1.
- BEQ i_zero=1 -> pc_en=1, pc_src=01; BNE i_zero=1 -> pc_en=0; BNE i_zero=0 -> pc_en=1.
- Opcode 6'h3F -> DECODE->FETCH, o_illegal_op=1 and stays 1 through following ADDI; reset clears it.
- SW with reset asserted while in MEMWR -> mem_write drops to 0 asynchronously, state=0 on release.
